// File: rtl/dcache_pkg.sv
// Shared types and opcode constants for the write-back, write-allocate data-cache controller.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    function automatic logic is_access(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Word-serial main-memory bus between the cache controller (master) and memory (slave).
interface dcache_if #(
    parameter int WORDS_PER_LINE = 4
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    logic             mem_req;
    logic             mem_we;
    logic             mem_in_select;
    logic [IDX_W-1:0] word_idx;
    logic             mem_ready;

    modport master (
        output mem_req, mem_we, mem_in_select, word_idx,
        input  mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_in_select, word_idx,
        output mem_ready
    );

endinterface

// File: rtl/dcache_line_counter.sv
// Word counter walking the words of one cache line; wraps naturally at the line size.
module dcache_line_counter #(
    parameter int WORDS_PER_LINE = 4,
    localparam int IDX_W = $clog2(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             inc,
    input  logic             clr,
    output logic [IDX_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + IDX_W'(1);
        end
    end

    assign last = (cnt == IDX_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache controller: single-cycle hits, dirty-victim writeback, line refill, replay.
// Optional DCACHE_PERF_CNT_EN adds hit/miss/writeback event counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [5:0]  opcode,
    input  logic        hit,
    input  logic        dirty,
    output logic        stall,
    output logic        reg_we,
    output logic        cache_we,
    output logic        cache_fill,
    output logic        set_dirty,
    output logic        fill_done,
    dcache_if.master    mem
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [31:0] wb_cnt
`endif
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] cnt;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             cnt_last;
    logic             access;

    assign access = is_access(opcode);

    dcache_line_counter #(
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_line_counter (
        .clk  (clk),
        .rst_b(rst_b),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        cnt_inc           = 1'b0;
        cnt_clr           = 1'b0;
        stall             = 1'b0;
        reg_we            = 1'b0;
        cache_we          = 1'b0;
        cache_fill        = 1'b0;
        set_dirty         = 1'b0;
        fill_done         = 1'b0;
        mem.mem_req       = 1'b0;
        mem.mem_we        = 1'b0;
        mem.mem_in_select = 1'b0;
        mem.word_idx      = '0;

        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (access) begin
                    if (hit) begin
                        reg_we    = (opcode == OP_LW);
                        cache_we  = (opcode == OP_SW);
                        set_dirty = (opcode == OP_SW);
                    end else begin
                        stall     = 1'b1;
                        state_nxt = dirty ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                stall             = 1'b1;
                mem.mem_req       = 1'b1;
                mem.mem_we        = 1'b1;
                mem.mem_in_select = 1'b1;
                mem.word_idx      = cnt;
                if (mem.mem_ready) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                stall        = 1'b1;
                mem.mem_req  = 1'b1;
                mem.word_idx = cnt;
                if (mem.mem_ready) begin
                    cnt_inc    = 1'b1;
                    cache_we   = 1'b1;
                    cache_fill = 1'b1;
                    if (cnt_last) begin
                        fill_done = 1'b1;
                        state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                stall     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are combinational from live inputs, so force them quiet while reset is held.
        if (!rst_b) begin
            stall             = 1'b0;
            reg_we            = 1'b0;
            cache_we          = 1'b0;
            cache_fill        = 1'b0;
            set_dirty         = 1'b0;
            fill_done         = 1'b0;
            mem.mem_req       = 1'b0;
            mem.mem_we        = 1'b0;
            mem.mem_in_select = 1'b0;
            mem.word_idx      = '0;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // replay marks the post-refill hit so it is not counted as a second hit.
    logic replay;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            replay   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (state == COMMIT) begin
                replay <= 1'b1;
            end
            if (state == IDLE && access) begin
                if (hit) begin
                    if (!replay) begin
                        hit_cnt <= hit_cnt + 32'd1;
                    end
                    replay <= 1'b0;
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                    if (dirty) begin
                        wb_cnt <= wb_cnt + 32'd1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: per-transaction expected traces built from the cache rules.
module tb_dcache_ctrl;

    localparam int WPL = 4;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;

    typedef struct packed {
        logic       stall;
        logic       reg_we;
        logic       cache_we;
        logic       cache_fill;
        logic       set_dirty;
        logic       fill_done;
        logic       mem_req;
        logic       mem_we;
        logic       mem_in_select;
        logic [1:0] word_idx;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic       hit;
        logic       dirty;
        logic       rdy;
        out_t       exp;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [5:0] opcode = '0;
    logic       hit = 1'b0;
    logic       dirty = 1'b0;
    logic       stall, reg_we, cache_we, cache_fill, set_dirty, fill_done;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    dcache_if #(.WORDS_PER_LINE(WPL)) mem_bus ();

    dcache_ctrl #(.WORDS_PER_LINE(WPL)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .opcode    (opcode),
        .hit       (hit),
        .dirty     (dirty),
        .stall     (stall),
        .reg_we    (reg_we),
        .cache_we  (cache_we),
        .cache_fill(cache_fill),
        .set_dirty (set_dirty),
        .fill_done (fill_done),
        .mem       (mem_bus.master)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .wb_cnt    (wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    cyc_t trace[$];
    out_t exp_now = '0;
    out_t act;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   stall_run = 0;
    int   last_stall_run = 0;
    int   txn_id = 0;
    int   m_hit = 0, m_miss = 0, m_wb = 0;

    assign act = {stall, reg_we, cache_we, cache_fill, set_dirty, fill_done,
                  mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_in_select, mem_bus.word_idx};

    task automatic checkOutput();
        n_checks++;
        if (act !== exp_now) begin
            n_fail++;
            $display("[TB] FAIL outputs txn=%0d t=%0t actual=%b required=%b", txn_id, $time, act, exp_now);
        end
    endtask

    task automatic checkLiteral(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput();
            if (act.stall) begin
                stall_run++;
            end else if (stall_run != 0) begin
                last_stall_run = stall_run;
                stall_run = 0;
            end
        end
    end

    task automatic push(input logic [5:0] op, input logic h, input logic d, input logic rdy, input out_t e);
        cyc_t c;
        c.op = op; c.hit = h; c.dirty = d; c.rdy = rdy; c.exp = e;
        trace.push_back(c);
    endtask

    task automatic pushHit(input logic [5:0] op, input logic d);
        out_t e = '0;
        if (op == LW) begin
            e.reg_we = 1'b1;
        end else begin
            e.cache_we  = 1'b1;
            e.set_dirty = 1'b1;
        end
        push(op, 1'b1, d, 1'($urandom), e);
    endtask

    // One line word: some wait cycles with mem_ready low, then the completing cycle.
    task automatic pushWord(input logic [5:0] op, input logic d, input logic wb, input int w, input int mode);
        out_t e = '0;
        int k;
        k = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
        e.stall = 1'b1; e.mem_req = 1'b1; e.mem_we = wb; e.mem_in_select = wb; e.word_idx = 2'(w);
        repeat (k) push(op, 1'b0, d, 1'b0, e);
        if (!wb) begin
            e.cache_we = 1'b1; e.cache_fill = 1'b1; e.fill_done = (w == WPL - 1);
        end
        push(op, 1'b0, d, 1'b1, e);
    endtask

    task automatic buildTxn(input logic [5:0] op, input logic h, input logic d, input int mode);
        out_t e = '0;
        if (!(op == LW || op == SW)) begin
            push(op, h, d, 1'($urandom), e);
            return;
        end
        if (h) begin
            m_hit++;
            pushHit(op, d);
            return;
        end
        m_miss++;
        if (d) m_wb++;
        e.stall = 1'b1;
        push(op, 1'b0, d, 1'($urandom), e);
        if (d) for (int w = 0; w < WPL; w++) pushWord(op, d, 1'b1, w, mode);
        for (int w = 0; w < WPL; w++) pushWord(op, d, 1'b0, w, mode);
        push(op, 1'b1, d, 1'($urandom), e);
        pushHit(op, d);
    endtask

    task automatic applyStimulus(input cyc_t c);
        opcode = c.op;
        hit = c.hit;
        dirty = c.dirty;
        mem_bus.mem_ready = c.rdy;
        exp_now = c.exp;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic runTrace();
        txn_id++;
        while (trace.size() > 0) applyStimulus(trace.pop_front());
    endtask

    initial begin
        cyc_t c;
        logic [5:0] op;
        mem_bus.mem_ready = 1'b1;
        opcode = LW; hit = 1'b1; dirty = 1'b0;
        exp_now = '0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;

        // Reset while the refill is on word 2.
        buildTxn(LW, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(trace.pop_front());
        c = trace.pop_front();
        trace.delete();
        opcode = c.op; hit = c.hit; dirty = c.dirty; mem_bus.mem_ready = c.rdy;
        rst_b = 1'b0;
        exp_now = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst_b = 1'b1;
        c.op = 6'b000000; c.hit = 1'b0; c.dirty = 1'b0; c.rdy = 1'b1; c.exp = '0;
        applyStimulus(c);
        checkLiteral("idx_after_reset", int'(mem_bus.word_idx), 0);
        m_hit = 0; m_miss = 0; m_wb = 0;

        buildTxn(LW, 1'b1, 1'b0, 0);
        checkLiteral("lw_hit_len", trace.size(), 1);
        runTrace();
        buildTxn(SW, 1'b1, 1'b0, 0);
        runTrace();
        buildTxn(LW, 1'b0, 1'b0, 0);
        checkLiteral("clean_miss_len", trace.size(), 7);
        runTrace();
        checkLiteral("clean_miss_stall", last_stall_run, 6);
        buildTxn(SW, 1'b0, 1'b1, 1);
        checkLiteral("dirty_miss_len", trace.size(), 19);
        runTrace();
        checkLiteral("dirty_miss_stall", last_stall_run, 18);
`ifdef DCACHE_PERF_CNT_EN
        checkLiteral("hit_cnt_directed", int'(hit_cnt), 2);
        checkLiteral("miss_cnt_directed", int'(miss_cnt), 2);
        checkLiteral("wb_cnt_directed", int'(wb_cnt), 1);
`endif

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: op = LW;
                1: op = SW;
                default: begin
                    op = 6'($urandom);
                    if (op == LW || op == SW) op = op ^ 6'b000001;
                end
            endcase
            buildTxn(op, 1'($urandom), 1'($urandom), 2);
            runTrace();
        end
        c.op = 6'b000000; c.hit = 1'b0; c.dirty = 1'b0; c.rdy = 1'b0; c.exp = '0;
        applyStimulus(c);
`ifdef DCACHE_PERF_CNT_EN
        checkLiteral("hit_cnt", int'(hit_cnt), m_hit);
        checkLiteral("miss_cnt", int'(miss_cnt), m_miss);
        checkLiteral("wb_cnt", int'(wb_cnt), m_wb);
`endif
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
